// File: rtl/vector_cmd_issue_pkg.sv
// Shared types and constants for the vector command issue stage.
//   - Field widths of the command word, thread ID, scalar operand and lane mask.
//   - vcmd_entry_t: one buffered command with its thread ID, lane mask and scalar operand.
//   - issue_state_t: states of the barrier FSM.
//   - is_sync(): the sync-barrier flag, which is the top bit of the command word.
package vector_cmd_issue_pkg;

   localparam int NUM_LANE       = 16;
   localparam int WIDTH_CMD      = 64;
   localparam int WIDTH_TID      = 8;
   localparam int WIDTH_DATA     = 32;
   localparam int WIDTH_INFLIGHT = 8;

   typedef logic [WIDTH_CMD-1:0]  cmd_t;
   typedef logic [WIDTH_TID-1:0]  tid_t;
   typedef logic [WIDTH_DATA-1:0] data_t;
   typedef logic [NUM_LANE-1:0]   lane_t;

   typedef struct packed {
      cmd_t  command;
      tid_t  thread_id;
      lane_t en_lane;
      data_t scalar;
   } vcmd_entry_t;

   typedef enum logic {
      ST_RUN       = 1'b0,
      ST_WAIT_SYNC = 1'b1
   } issue_state_t;

   function automatic logic is_sync(input cmd_t command);
      return command[WIDTH_CMD-1];
   endfunction

endpackage

// File: rtl/vcmd_fifo.sv
// Circular FIFO of vcmd_entry_t with DEPTH entries.
// DEPTH must be a power of two and at least 2.
// Ports:
//   clock, reset    : system clock and synchronous active-low reset
//   push, push_entry: write request and the entry to write (ignored while full)
//   pop             : read request (ignored while empty)
//   head_entry      : entry at the read pointer, valid while !empty
//   full, empty     : status, derived from the registered pointers
//   count           : number of entries held
module vcmd_fifo
   import vector_cmd_issue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  vcmd_entry_t              push_entry,
   input  logic                     pop,
   output vcmd_entry_t              head_entry,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   // The pointers carry one extra wrap bit, so a full FIFO and an empty FIFO
   // are told apart even though their index bits are equal.
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   vcmd_entry_t  mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count      = wr_ptr - rd_ptr;
   assign do_push    = push & ~full;
   assign do_pop     = pop & ~empty;
   assign head_entry = mem[rd_ptr[AW-1:0]];

   // NOTE: sequential state uses non-blocking assignments, so every flop
   // samples the values from before the edge regardless of statement order.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array has no reset. The pointers alone decide which
   // entries are valid, so clearing the array would only add reset fan-out.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
   end

endmodule

// File: rtl/vector_cmd_issue.sv
// Vector command issue stage, sitting directly in front of the vector unit.
// Commands from the front-end sequencer are buffered in a small FIFO and
// issued one per cycle. The stage counts issued-but-uncommitted commands and
// holds a sync-barrier command until every earlier command has committed.
// Optional macro VCMD_ISSUE_PERF_EN adds the O_Stall_Cnt output, which counts
// the cycles in which the FIFO holds work but nothing issues.
// Ports:
//   clock, reset              : system clock and synchronous active-low reset
//   I_Req / O_Ack             : front-end valid and ready; a push happens on I_Req & O_Ack
//   I_Command, I_ThreadID,
//   I_En_Lane, I_Scalar_Data  : command payload written into the FIFO
//   I_Stall                   : the vector unit cannot accept a command this cycle
//   O_Issue + O_* payload     : registered issue strobe and the issued command
//   I_Commit_Req              : one pulse per command the vector unit retires
//   O_InFlight                : number of commands issued and not yet committed
//   O_Stall_Cnt (optional)    : saturating count of cycles with work but no issue
//   O_Idle                    : registered; FIFO empty and nothing in flight
module vector_cmd_issue
   import vector_cmd_issue_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      I_Req,
   output logic                      O_Ack,
   input  logic [WIDTH_CMD-1:0]      I_Command,
   input  logic [WIDTH_TID-1:0]      I_ThreadID,
   input  logic [NUM_LANE-1:0]       I_En_Lane,
   input  logic [WIDTH_DATA-1:0]     I_Scalar_Data,
   input  logic                      I_Stall,
   output logic                      O_Issue,
   output logic [WIDTH_CMD-1:0]      O_Command,
   output logic [WIDTH_TID-1:0]      O_ThreadID,
   output logic [NUM_LANE-1:0]       O_En_Lane,
   output logic [WIDTH_DATA-1:0]     O_Scalar_Data,
   input  logic                      I_Commit_Req,
   output logic [WIDTH_INFLIGHT-1:0] O_InFlight,
`ifdef VCMD_ISSUE_PERF_EN
   output logic [31:0]               O_Stall_Cnt,
`endif
   output logic                      O_Idle
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [WIDTH_INFLIGHT-1:0] MAX_IF = WIDTH_INFLIGHT'(MAX_INFLIGHT);

   vcmd_entry_t               push_entry;
   vcmd_entry_t               head_entry;
   logic                      full;
   logic                      empty;
   logic [AW:0]               count;
   logic [AW:0]               count_next;
   logic                      push;
   logic                      barrier_block;
   logic                      can_issue;
   logic [WIDTH_INFLIGHT-1:0] inflight_next;
   issue_state_t              state;

   assign push_entry = '{command:   I_Command,
                         thread_id: I_ThreadID,
                         en_lane:   I_En_Lane,
                         scalar:    I_Scalar_Data};

   assign O_Ack = ~full;
   assign push  = I_Req & O_Ack;

   vcmd_fifo #(
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (can_issue),
      .head_entry (head_entry),
      .full       (full),
      .empty      (empty),
      .count      (count)
   );

   // A sync command at the head may issue only when nothing earlier is still in flight.
   assign barrier_block = ~empty & is_sync(head_entry.command) & (O_InFlight != '0);

   assign can_issue = ~empty & ~I_Stall & (O_InFlight < MAX_IF)
                    & (state == ST_RUN) & ~barrier_block;

   assign count_next = count + (AW+1)'(push) - (AW+1)'(can_issue);

   // An issue and a commit in the same cycle cancel. A commit at zero is a
   // protocol error, and the counter stays at zero.
   // NOTE: give every always_comb output a default first, so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      inflight_next = O_InFlight;
      if (can_issue && !I_Commit_Req)
         inflight_next = O_InFlight + 1'b1;
      else if (!can_issue && I_Commit_Req && (O_InFlight != '0))
         inflight_next = O_InFlight - 1'b1;
   end

   // Barrier FSM, in-flight counter and registered issue outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= ST_RUN;
         O_Issue       <= 1'b0;
         O_Command     <= '0;
         O_ThreadID    <= '0;
         O_En_Lane     <= '0;
         O_Scalar_Data <= '0;
         O_InFlight    <= '0;
         O_Idle        <= 1'b1;
`ifdef VCMD_ISSUE_PERF_EN
         O_Stall_Cnt   <= '0;
`endif
      end else begin
         O_Issue <= can_issue;
         if (can_issue) begin
            O_Command     <= head_entry.command;
            O_ThreadID    <= head_entry.thread_id;
            O_En_Lane     <= head_entry.en_lane;
            O_Scalar_Data <= head_entry.scalar;
         end else begin
            O_Command     <= '0;
            O_ThreadID    <= '0;
            O_En_Lane     <= '0;
            O_Scalar_Data <= '0;
         end

         O_InFlight <= inflight_next;
         // O_Idle is built from next-state values, so it describes the same
         // cycle as O_InFlight and the FIFO state.
         O_Idle     <= (count_next == '0) && (inflight_next == '0);

         unique case (state)
            ST_RUN:       if (barrier_block)          state <= ST_WAIT_SYNC;
            ST_WAIT_SYNC: if (inflight_next == '0)    state <= ST_RUN;
            default:                                  state <= ST_RUN;
         endcase

`ifdef VCMD_ISSUE_PERF_EN
         if (!empty && !can_issue && (O_Stall_Cnt != '1))
            O_Stall_Cnt <= O_Stall_Cnt + 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_vector_cmd_issue.sv
// Self-checking bench for vector_cmd_issue. A transaction-level reference
// model (a queue of commands, an integer in-flight count and a barrier-wait
// flag) predicts the outputs for each cycle. Directed scenarios are followed
// by a randomized phase.
module tb_vector_cmd_issue;
   import vector_cmd_issue_pkg::*;

   localparam int DEPTH        = 4;
   localparam int MAX_INFLIGHT = 8;

   logic                      clock = 1'b0;
   logic                      reset;
   logic                      I_Req;
   logic                      O_Ack;
   logic [WIDTH_CMD-1:0]      I_Command;
   logic [WIDTH_TID-1:0]      I_ThreadID;
   logic [NUM_LANE-1:0]       I_En_Lane;
   logic [WIDTH_DATA-1:0]     I_Scalar_Data;
   logic                      I_Stall;
   logic                      O_Issue;
   logic [WIDTH_CMD-1:0]      O_Command;
   logic [WIDTH_TID-1:0]      O_ThreadID;
   logic [NUM_LANE-1:0]       O_En_Lane;
   logic [WIDTH_DATA-1:0]     O_Scalar_Data;
   logic                      I_Commit_Req;
   logic [WIDTH_INFLIGHT-1:0] O_InFlight;
   logic                      O_Idle;
`ifdef VCMD_ISSUE_PERF_EN
   logic [31:0]               O_Stall_Cnt;
`endif

   always #5 clock = ~clock;

   vector_cmd_issue #(
      .DEPTH         (DEPTH),
      .MAX_INFLIGHT  (MAX_INFLIGHT)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .I_Req         (I_Req),
      .O_Ack         (O_Ack),
      .I_Command     (I_Command),
      .I_ThreadID    (I_ThreadID),
      .I_En_Lane     (I_En_Lane),
      .I_Scalar_Data (I_Scalar_Data),
      .I_Stall       (I_Stall),
      .O_Issue       (O_Issue),
      .O_Command     (O_Command),
      .O_ThreadID    (O_ThreadID),
      .O_En_Lane     (O_En_Lane),
      .O_Scalar_Data (O_Scalar_Data),
      .I_Commit_Req  (I_Commit_Req),
      .O_InFlight    (O_InFlight),
`ifdef VCMD_ISSUE_PERF_EN
      .O_Stall_Cnt   (O_Stall_Cnt),
`endif
      .O_Idle        (O_Idle)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Reference model state
   vcmd_entry_t m_q[$];
   int          m_inflight;
   bit          m_wait;
   longint      m_stall_cnt;
   bit          exp_issue;
   vcmd_entry_t exp_e;

   // Commands waiting to be offered to the DUT
   vcmd_entry_t pending[$];

   task automatic model_reset();
      m_q.delete();
      m_inflight  = 0;
      m_wait      = 0;
      m_stall_cnt = 0;
      exp_issue   = 0;
      exp_e       = '0;
   endtask

   function automatic vcmd_entry_t new_entry(input bit sync);
      vcmd_entry_t e;
      e.command                = {$urandom, $urandom};
      e.command[WIDTH_CMD-1]   = sync;
      e.thread_id              = WIDTH_TID'($urandom);
      e.en_lane                = ($urandom_range(0, 3) == 0) ? '0 : NUM_LANE'($urandom);
      e.scalar                 = $urandom;
      return e;
   endfunction

   // Apply one cycle of stimulus, advance the model, then compare after the edge.
   task automatic tick(input bit stall, input bit commit, input bit gap);
      bit          req;
      bit          accepted;
      bit          head_sync;
      bit          blocked;
      vcmd_entry_t e;
      @(negedge clock);
      req = (pending.size() > 0) && !gap;
      e   = req ? pending[0] : '0;
      I_Req         = req;
      I_Command     = e.command;
      I_ThreadID    = e.thread_id;
      I_En_Lane     = e.en_lane;
      I_Scalar_Data = e.scalar;
      I_Stall       = stall;
      I_Commit_Req  = commit;
      check("ack", O_Ack, 64'(m_q.size() < DEPTH));

      // Model: decide the issue from the state before the edge, then apply the push.
      accepted  = req && (m_q.size() < DEPTH);
      head_sync = (m_q.size() > 0) && m_q[0].command[WIDTH_CMD-1];
      blocked   = head_sync && (m_inflight != 0);
      exp_issue = (m_q.size() > 0) && !stall && (m_inflight < MAX_INFLIGHT) && !m_wait && !blocked;
      if ((m_q.size() > 0) && !exp_issue && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      exp_e = exp_issue ? m_q.pop_front() : '0;
      if (exp_issue && !commit)                      m_inflight++;
      else if (!exp_issue && commit && m_inflight > 0) m_inflight--;
      if (m_wait) begin
         if (m_inflight == 0) m_wait = 0;
      end else if (blocked) begin
         m_wait = 1;
      end
      if (accepted) begin
         m_q.push_back(e);
         void'(pending.pop_front());
      end

      @(posedge clock);
      #1;
      check("issue", O_Issue, 64'(exp_issue));
      check("command", O_Command, exp_e.command);
      check("en_lane", O_En_Lane, 64'(exp_e.en_lane));
      if (exp_issue) begin
         check("thread_id", O_ThreadID, 64'(exp_e.thread_id));
         check("scalar", O_Scalar_Data, 64'(exp_e.scalar));
      end
      check("inflight", O_InFlight, 64'(m_inflight));
      check("idle", O_Idle, 64'((m_q.size() == 0) && (m_inflight == 0)));
`ifdef VCMD_ISSUE_PERF_EN
      check("stall_cnt", O_Stall_Cnt, 64'(m_stall_cnt));
`endif
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset        = 1'b0;
      I_Req        = 1'b0;
      I_Stall      = 1'b0;
      I_Commit_Req = 1'b0;
      @(posedge clock);
      #1;
      model_reset();
      pending.delete();
      check("rst_issue", O_Issue, 0);
      check("rst_command", O_Command, 0);
      check("rst_en_lane", O_En_Lane, 0);
      check("rst_inflight", O_InFlight, 0);
      check("rst_ack", O_Ack, 1);
      check("rst_idle", O_Idle, 1);
      @(negedge clock);
      reset = 1'b1;
   endtask

   // Offer any pending commands and commit everything until the model is idle.
   task automatic drain(input string tag);
      for (int i = 0; i < 200; i++) begin
         if (pending.size() == 0 && m_q.size() == 0 && m_inflight == 0) break;
         tick(1'b0, m_inflight > 0, 1'b0);
      end
      check(tag, 64'(pending.size() == 0 && m_q.size() == 0 && m_inflight == 0), 1);
      check({tag, "_idle"}, O_Idle, 1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; I_Req = 0; I_Command = '0; I_ThreadID = '0; I_En_Lane = '0;
      I_Scalar_Data = '0; I_Stall = 0; I_Commit_Req = 0;
      model_reset();
      repeat (2) @(posedge clock);
      apply_reset();

      // Three commands buffered under stall, then discarded by a reset
      repeat (3) pending.push_back(new_entry(0));
      repeat (3) tick(1'b1, 1'b0, 1'b0);
      apply_reset();
      repeat (4) tick(1'b0, 1'b0, 1'b0);
      check("discard_idle", O_Idle, 1);

      // Four back-to-back commands, no stall, no commits
      repeat (4) pending.push_back(new_entry(0));
      repeat (6) tick(1'b0, 1'b0, 1'b0);
      check("b2b_inflight", O_InFlight, 4);
      drain("drain_b2b");

      // Five commands under stall: the FIFO fills and the fifth is held off
      repeat (5) pending.push_back(new_entry(0));
      repeat (5) tick(1'b1, 1'b0, 1'b0);
      check("full_ack", O_Ack, 0);
      check("full_held", 64'(pending.size()), 1);
      repeat (8) tick(1'b0, 1'b0, 1'b0);
      check("full_inflight", O_InFlight, 5);
      drain("drain_full");

      // In-flight limit: ten commands, no commits
      repeat (10) pending.push_back(new_entry(0));
      repeat (14) tick(1'b0, 1'b0, 1'b0);
      check("limit_inflight", O_InFlight, MAX_INFLIGHT);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      check("limit_ninth", O_Issue, 1);
      check("limit_inflight2", O_InFlight, MAX_INFLIGHT);
      drain("drain_limit");

      // Sync barrier behind two in-flight commands
      pending.push_back(new_entry(0));
      pending.push_back(new_entry(0));
      pending.push_back(new_entry(1));
      repeat (6) tick(1'b0, 1'b0, 1'b0);
      check("sync_wait_state", 64'(dut.state == ST_WAIT_SYNC), 1);
      check("sync_wait_inflight", O_InFlight, 2);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      check("sync_zero", O_InFlight, 0);
      tick(1'b0, 1'b0, 1'b0);
      check("sync_issue", O_Issue, 1);
      check("sync_flag", 64'(O_Command[WIDTH_CMD-1]), 1);
      drain("drain_sync");

      // Issue and commit together at three in flight; commit at zero
      repeat (4) pending.push_back(new_entry(0));
      repeat (4) tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      check("same_cycle_issue", O_Issue, 1);
      check("same_cycle_inflight", O_InFlight, 3);
      drain("drain_same");
      tick(1'b0, 1'b1, 1'b0);
      check("commit_at_zero", O_InFlight, 0);

      // Randomized traffic, with one reset in the middle
      for (int i = 0; i < 1500; i++) begin
         if (pending.size() < 2 && $urandom_range(0, 9) < 7)
            pending.push_back(new_entry($urandom_range(0, 7) == 0));
         if (i == 700) apply_reset();
         tick($urandom_range(0, 3) == 0,
              (m_inflight > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 29) == 0),
              $urandom_range(0, 7) == 0);
      end
      drain("drain_random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
      $finish;
   end

endmodule
